// File: rtl/hpdcache_refill_seq.sv
// Refill sequencer: streams memory response beats of one cache line into the data RAM,
// then writes the directory entry and releases the MSHR. Optional macro: HPDCACHE_REFILL_ERROR_EN.
module hpdcache_refill_seq #(
   parameter int PA_WIDTH      = 49,
   parameter int SETS          = 128,
   parameter int WAYS          = 4,
   parameter int WORD_WIDTH    = 64,
   parameter int CL_WORDS      = 8,
   parameter int ACCESS_WORDS  = 4,
   parameter int MSHR_ID_WIDTH = 7,
   localparam int BEATS  = CL_WORDS / ACCESS_WORDS,
   localparam int SET_W  = $clog2(SETS),
   localparam int WIDX_W = $clog2(CL_WORDS),
   localparam int TAG_W  = PA_WIDTH - SET_W - $clog2(CL_WORDS * WORD_WIDTH / 8),
   localparam int DW     = ACCESS_WORDS * WORD_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     mem_resp_valid_i,
   output logic                     mem_resp_ready_o,
   input  logic [MSHR_ID_WIDTH-1:0] mem_resp_id_i,
   input  logic [DW-1:0]            mem_resp_data_i,
   input  logic                     mem_resp_last_i,
   input  logic                     mem_resp_error_i,
   output logic [MSHR_ID_WIDTH-1:0] mshr_lookup_id_o,
   input  logic [SET_W-1:0]         mshr_set_i,
   input  logic [TAG_W-1:0]         mshr_tag_i,
   input  logic [WAYS-1:0]          mshr_way_i,
   output logic                     data_req_o,
   input  logic                     data_gnt_i,
   output logic [SET_W-1:0]         data_set_o,
   output logic [WAYS-1:0]          data_way_o,
   output logic [WIDX_W-1:0]        data_word_o,
   output logic [DW-1:0]            data_wdata_o,
   output logic                     dir_req_o,
   input  logic                     dir_gnt_i,
   output logic [SET_W-1:0]         dir_set_o,
   output logic [WAYS-1:0]          dir_way_o,
   output logic [TAG_W-1:0]         dir_tag_o,
   output logic                     dir_valid_o,
   output logic                     mshr_ack_o,
   output logic [MSHR_ID_WIDTH-1:0] mshr_ack_id_o,
   output logic                     mshr_ack_err_o,
   output logic                     busy_o
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {IDLE, WRITE, NEXT, DIR, ACK} state_e;

   state_e                   state_q, state_d;
   logic [MSHR_ID_WIDTH-1:0] id_q, id_d;
   logic [SET_W-1:0]         set_q, set_d;
   logic [TAG_W-1:0]         tag_q, tag_d;
   logic [WAYS-1:0]          way_q, way_d;
   logic [DW-1:0]            data_q, data_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic                     err_q, err_d;

   logic err_in, line_valid, ack_err;

`ifdef HPDCACHE_REFILL_ERROR_EN
   assign err_in     = mem_resp_error_i;
   assign line_valid = ~err_q;
   assign ack_err    = err_q;
`else
   logic unused_err;
   assign unused_err = mem_resp_error_i ^ err_q;
   assign err_in     = 1'b0;
   assign line_valid = 1'b1;
   assign ack_err    = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         id_q    <= '0;
         set_q   <= '0;
         tag_q   <= '0;
         way_q   <= '0;
         data_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         set_q   <= set_d;
         tag_q   <= tag_d;
         way_q   <= way_d;
         data_q  <= data_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      id_d             = id_q;
      set_d            = set_q;
      tag_d            = tag_q;
      way_d            = way_q;
      data_d           = data_q;
      beat_d           = beat_q;
      err_d            = err_q;
      mem_resp_ready_o = 1'b0;
      data_req_o       = 1'b0;
      dir_req_o        = 1'b0;
      dir_valid_o      = 1'b0;
      mshr_ack_o       = 1'b0;
      mshr_ack_err_o   = 1'b0;
      case (state_q)
         IDLE: begin
            mem_resp_ready_o = 1'b1;
            if (mem_resp_valid_i) begin
               id_d    = mem_resp_id_i;
               set_d   = mshr_set_i;
               tag_d   = mshr_tag_i;
               way_d   = mshr_way_i;
               data_d  = mem_resp_data_i;
               beat_d  = '0;
               err_d   = err_in;
               state_d = WRITE;
            end
         end
         WRITE: begin
            data_req_o = 1'b1;
            if (data_gnt_i) begin
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  state_d = DIR;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  state_d = NEXT;
               end
            end
         end
         NEXT: begin
            // Only the payload advances per beat; line identity stays from the first beat.
            mem_resp_ready_o = 1'b1;
            if (mem_resp_valid_i) begin
               data_d  = mem_resp_data_i;
               err_d   = err_q | err_in;
               state_d = WRITE;
            end
         end
         DIR: begin
            dir_req_o   = 1'b1;
            dir_valid_o = line_valid;
            if (dir_gnt_i) state_d = ACK;
         end
         ACK: begin
            mshr_ack_o     = 1'b1;
            mshr_ack_err_o = ack_err;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mshr_lookup_id_o = mem_resp_id_i;
   assign data_set_o       = set_q;
   assign data_way_o       = way_q;
   assign data_word_o      = WIDX_W'(beat_q * ACCESS_WORDS);
   assign data_wdata_o     = data_q;
   assign dir_set_o        = set_q;
   assign dir_way_o        = way_q;
   assign dir_tag_o        = tag_q;
   assign mshr_ack_id_o    = id_q;
   assign busy_o           = (state_q != IDLE);

   // Protocol checks on the response stream; they never alter the sequencing.
   logic [BEAT_W-1:0] acc_beat;
   assign acc_beat = (state_q == NEXT) ? beat_q : '0;

   always @(posedge clk_i) begin
      if (rst_ni && mem_resp_valid_i && mem_resp_ready_o) begin
         assert (mem_resp_last_i == (acc_beat == BEAT_W'(BEATS - 1)))
            else $error("refill: last marker on wrong beat");
         if (state_q == NEXT)
            assert (mem_resp_id_i == id_q)
               else $error("refill: beat id differs from latched id");
      end
   end

endmodule

// File: tb/tb_hpdcache_refill_seq.sv
// Directed bench for hpdcache_refill_seq with default parameters (2 beats per line).
module tb_hpdcache_refill_seq;

   logic         clk, rst_n;
   logic         mem_resp_valid_i, mem_resp_ready_o, mem_resp_last_i, mem_resp_error_i;
   logic [6:0]   mem_resp_id_i, mshr_lookup_id_o, mshr_ack_id_o;
   logic [255:0] mem_resp_data_i, data_wdata_o;
   logic [6:0]   mshr_set_i, data_set_o, dir_set_o;
   logic [35:0]  mshr_tag_i, dir_tag_o;
   logic [3:0]   mshr_way_i, data_way_o, dir_way_o;
   logic         data_req_o, data_gnt_i, dir_req_o, dir_gnt_i, dir_valid_o;
   logic [2:0]   data_word_o;
   logic         mshr_ack_o, mshr_ack_err_o, busy_o;

   int n_cmp = 0;
   int n_err = 0;

`ifdef HPDCACHE_REFILL_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   hpdcache_refill_seq dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
      .mem_resp_id_i(mem_resp_id_i), .mem_resp_data_i(mem_resp_data_i),
      .mem_resp_last_i(mem_resp_last_i), .mem_resp_error_i(mem_resp_error_i),
      .mshr_lookup_id_o(mshr_lookup_id_o), .mshr_set_i(mshr_set_i),
      .mshr_tag_i(mshr_tag_i), .mshr_way_i(mshr_way_i),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_set_o(data_set_o),
      .data_way_o(data_way_o), .data_word_o(data_word_o), .data_wdata_o(data_wdata_o),
      .dir_req_o(dir_req_o), .dir_gnt_i(dir_gnt_i), .dir_set_o(dir_set_o),
      .dir_way_o(dir_way_o), .dir_tag_o(dir_tag_o), .dir_valid_o(dir_valid_o),
      .mshr_ack_o(mshr_ack_o), .mshr_ack_id_o(mshr_ack_id_o),
      .mshr_ack_err_o(mshr_ack_err_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   function automatic logic [255:0] mk(input logic [7:0] b);
      logic [255:0] r;
      for (int i = 0; i < 4; i++) r[i*64 +: 64] = {b, 48'h0, 8'(i)};
      return r;
   endfunction

   task automatic lookup(input logic [6:0] s, input logic [35:0] t, input logic [3:0] w);
      mshr_set_i = s; mshr_tag_i = t; mshr_way_i = w;
   endtask

   task automatic offer(input logic [6:0] id, input logic [255:0] d, input logic last, input logic e);
      mem_resp_valid_i = 1'b1; mem_resp_id_i = id; mem_resp_data_i = d;
      mem_resp_last_i = last; mem_resp_error_i = e;
   endtask

   // Full 2-beat refill, all grants high, beat 1 offered back-to-back; starts at a negedge in IDLE.
   task automatic refill_fast(input logic [6:0] id, input logic [6:0] s, input logic [35:0] t,
                              input logic [3:0] w, input logic [255:0] d0, input logic [255:0] d1,
                              input logic e0, input logic e1, input logic exp_v, input logic exp_e);
      lookup(s, t, w);
      offer(id, d0, 1'b0, e0);
      chk("rf_idle_ready", mem_resp_ready_o, 1);
      chk("rf_lookup_id", mshr_lookup_id_o, id);
      nxt();
      chk("rf_w0_req", data_req_o, 1);
      chk("rf_w0_word", data_word_o, 0);
      chk("rf_w0_data", data_wdata_o, d0);
      chk("rf_w0_set", data_set_o, s);
      chk("rf_w0_way", data_way_o, w);
      chk("rf_w0_ready", mem_resp_ready_o, 0);
      chk("rf_w0_busy", busy_o, 1);
      offer(id, d1, 1'b1, e1);
      nxt();
      chk("rf_next_ready", mem_resp_ready_o, 1);
      chk("rf_next_req", data_req_o, 0);
      nxt();
      chk("rf_w1_req", data_req_o, 1);
      chk("rf_w1_word", data_word_o, 4);
      chk("rf_w1_data", data_wdata_o, d1);
      mem_resp_valid_i = 1'b0;
      nxt();
      chk("rf_dir_req", dir_req_o, 1);
      chk("rf_dir_valid", dir_valid_o, exp_v);
      chk("rf_dir_tag", dir_tag_o, t);
      chk("rf_dir_set", dir_set_o, s);
      chk("rf_dir_way", dir_way_o, w);
      chk("rf_dir_noack", mshr_ack_o, 0);
      nxt();
      chk("rf_ack", mshr_ack_o, 1);
      chk("rf_ack_id", mshr_ack_id_o, id);
      chk("rf_ack_err", mshr_ack_err_o, exp_e);
      nxt();
      chk("rf_ack_pulse", mshr_ack_o, 0);
      chk("rf_done_busy", busy_o, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      mem_resp_valid_i = 1'b0; mem_resp_id_i = '0; mem_resp_data_i = '0;
      mem_resp_last_i = 1'b0; mem_resp_error_i = 1'b0;
      lookup('0, '0, '0);
      data_gnt_i = 1'b1; dir_gnt_i = 1'b1;

      // reset state
      nxt();
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", mem_resp_ready_o, 1);
      chk("rst_data_req", data_req_o, 0);
      chk("rst_dir_req", dir_req_o, 0);
      chk("rst_dir_valid", dir_valid_o, 0);
      chk("rst_ack", mshr_ack_o, 0);
      chk("rst_wdata", data_wdata_o, 0);
      chk("rst_ack_id", mshr_ack_id_o, 0);
      rst_n = 1'b1;
      nxt();

      // basic refill: ack lands in the 6th cycle counting the acceptance cycle
      refill_fast(7'd5, 7'h12, 36'h9_ABCD_1234, 4'b0100, mk(8'hA0), mk(8'hB0),
                  1'b0, 1'b0, 1'b1, 1'b0);

      // data grant withheld for 3 cycles on beat 0
      data_gnt_i = 1'b0;
      lookup(7'h7f, 36'h1_2345_6789, 4'b0001);
      offer(7'd3, mk(8'hC0), 1'b0, 1'b0);
      nxt();
      for (int k = 0; k < 4; k++) begin
         chk("stall_req", data_req_o, 1);
         chk("stall_word", data_word_o, 0);
         chk("stall_data", data_wdata_o, mk(8'hC0));
         chk("stall_set", data_set_o, 7'h7f);
         chk("stall_way", data_way_o, 4'b0001);
         chk("stall_ready", mem_resp_ready_o, 0);
         if (k == 0) offer(7'd3, mk(8'hD0), 1'b1, 1'b0);
         if (k == 3) data_gnt_i = 1'b1;
         nxt();
      end
      chk("stall_next_ready", mem_resp_ready_o, 1);
      nxt();
      chk("stall_w1_word", data_word_o, 4);
      chk("stall_w1_data", data_wdata_o, mk(8'hD0));
      mem_resp_valid_i = 1'b0;
      nxt();
      chk("stall_dir_req", dir_req_o, 1);
      nxt();
      chk("stall_ack", mshr_ack_o, 1);
      chk("stall_ack_id", mshr_ack_id_o, 3);
      nxt();

      // directory grant withheld for 4 cycles
      dir_gnt_i = 1'b0;
      lookup(7'h01, 36'h0_0000_0042, 4'b1000);
      offer(7'd6, mk(8'hE0), 1'b0, 1'b0);
      nxt();
      offer(7'd6, mk(8'hE1), 1'b1, 1'b0);
      nxt();
      nxt();
      mem_resp_valid_i = 1'b0;
      nxt();
      for (int k = 0; k < 5; k++) begin
         chk("dgnt_dir_req", dir_req_o, 1);
         chk("dgnt_no_ack", mshr_ack_o, 0);
         if (k == 4) dir_gnt_i = 1'b1;
         nxt();
      end
      chk("dgnt_ack", mshr_ack_o, 1);
      chk("dgnt_ack_id", mshr_ack_id_o, 6);
      chk("dgnt_dir_idle", dir_req_o, 0);
      nxt();
      chk("dgnt_ack_pulse", mshr_ack_o, 0);

      // bus error on beat 1
      refill_fast(7'd7, 7'h33, 36'h5_5555_AAAA, 4'b0010, mk(8'h10), mk(8'h11),
                  1'b0, 1'b1, !ERR_EN, ERR_EN);

      // reset pulsed in NEXT discards the refill
      lookup(7'h44, 36'h7_7777_0000, 4'b0001);
      offer(7'd8, mk(8'h80), 1'b0, 1'b0);
      nxt();
      mem_resp_valid_i = 1'b0;
      nxt();
      chk("mrst_in_next", mem_resp_ready_o, 1);
      chk("mrst_busy_pre", busy_o, 1);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy_o, 0);
      chk("mrst_ready", mem_resp_ready_o, 1);
      chk("mrst_ack", mshr_ack_o, 0);
      chk("mrst_req", data_req_o, 0);
      nxt();
      rst_n = 1'b1;
      nxt();
      chk("mrst_no_ack", mshr_ack_o, 0);
      chk("mrst_idle", busy_o, 0);
      refill_fast(7'd9, 7'h55, 36'h3_0303_0303, 4'b0100, mk(8'h90), mk(8'h91),
                  1'b0, 1'b0, 1'b1, 1'b0);

      // back-to-back refills id 1 then id 2
      lookup(7'h01, 36'h1_1111_1111, 4'b0001);
      offer(7'd1, mk(8'h20), 1'b0, 1'b0);
      nxt();
      chk("b2b_w0_data", data_wdata_o, mk(8'h20));
      offer(7'd1, mk(8'h21), 1'b1, 1'b0);
      nxt();
      nxt();
      chk("b2b_w1_data", data_wdata_o, mk(8'h21));
      lookup(7'h02, 36'h2_2222_2222, 4'b0010);
      offer(7'd2, mk(8'h30), 1'b0, 1'b0);
      nxt();
      chk("b2b_dir_set", dir_set_o, 7'h01);
      chk("b2b_dir_tag", dir_tag_o, 36'h1_1111_1111);
      nxt();
      chk("b2b_ack1", mshr_ack_o, 1);
      chk("b2b_ack1_id", mshr_ack_id_o, 1);
      chk("b2b_ack1_ready", mem_resp_ready_o, 0);
      nxt();
      chk("b2b_idle_ready", mem_resp_ready_o, 1);
      chk("b2b_idle_busy", busy_o, 0);
      chk("b2b_idle_noack", mshr_ack_o, 0);
      nxt();
      chk("b2b_2_busy", busy_o, 1);
      chk("b2b_2_data", data_wdata_o, mk(8'h30));
      chk("b2b_2_set", data_set_o, 7'h02);
      offer(7'd2, mk(8'h31), 1'b1, 1'b0);
      nxt();
      nxt();
      chk("b2b_2_w1", data_wdata_o, mk(8'h31));
      mem_resp_valid_i = 1'b0;
      nxt();
      chk("b2b_2_dir_tag", dir_tag_o, 36'h2_2222_2222);
      nxt();
      chk("b2b_ack2", mshr_ack_o, 1);
      chk("b2b_ack2_id", mshr_ack_id_o, 2);
      nxt();
      chk("b2b_ack2_pulse", mshr_ack_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
